// File: rtl/ldpc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ldpc_pkg
// Description : Shared LDPC code constants, encoder state encoding and the
//               codeword bit-order convention.
// Revision    : 1.0 - initial release
// ============================================================================
package ldpc_pkg;

    localparam int N           = 256;
    localparam int K           = 128;
    localparam int M           = N - K;
    localparam int PAR_PER_CYC = 8;

    // Codeword layout: cw[N-1:MSG_LSB] = message, cw[MSG_LSB-1:0] = parity,
    // parity bit i sits at cw[i].
    localparam int MSG_LSB = K;

    typedef logic [1:0] state_t;
    localparam state_t c_IDLE = 2'd0;
    localparam state_t c_CALC = 2'd1;
    localparam state_t c_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/ldpc_parity_row.sv
`default_nettype none
// ============================================================================
// Module      : ldpc_parity_row
// Description : One parity row over GF(2): AND of message and row, XOR-reduced.
// Revision    : 1.0 - initial release
// ============================================================================
module ldpc_parity_row
    import ldpc_pkg::*;
#(
    parameter int K = ldpc_pkg::K
) (
    input  logic [K-1:0] i_msg,
    input  logic [K-1:0] i_row,
    output logic         o_par
);

    assign o_par = ^(i_msg & i_row);

endmodule
`default_nettype wire

// File: rtl/ldpc_encoder.sv
`default_nettype none
// ============================================================================
// Module      : ldpc_encoder
// Description : Systematic LDPC encoder, PAR_PER_CYC parity rows per clock,
//               one-cycle valid pulse with the registered codeword.
// Revision    : 1.0 - initial release
// ============================================================================
module ldpc_encoder
    import ldpc_pkg::*;
#(
    parameter int N           = ldpc_pkg::N,
    parameter int K           = ldpc_pkg::K,
    parameter int PAR_PER_CYC = ldpc_pkg::PAR_PER_CYC
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         work,
    input  logic [K-1:0] msg,
    output logic         free,
    output logic [N-1:0] cw,
    output logic         valid
);

    localparam int c_M      = N - K;
    localparam int c_GROUPS = c_M / PAR_PER_CYC;
    localparam int c_GW     = (c_GROUPS > 1) ? $clog2(c_GROUPS) : 1;
    localparam int c_IW     = (c_M > 1) ? $clog2(c_M) : 1;
    localparam logic [c_GW-1:0] c_LAST_GRP = c_GW'(c_GROUPS - 1);

    // Parity-generator matrix, filled from outside by hierarchical load.
    logic [K-1:0] Parray [0:c_M-1];

    state_t          r_state;
    logic [c_GW-1:0] r_grp;
    logic [K-1:0]    r_msg;
    logic [c_M-1:0]  r_par;

    logic [PAR_PER_CYC-1:0]            w_par_bits;
    logic [PAR_PER_CYC-1:0][c_IW-1:0]  w_row_idx;
    logic [c_M-1:0]                    w_par_next;

    generate
        for (genvar j = 0; j < PAR_PER_CYC; j++) begin : g_row
            assign w_row_idx[j] = c_IW'(r_grp) * c_IW'(PAR_PER_CYC) + c_IW'(j);

            ldpc_parity_row #(
                .K (K)
            ) u_row (
                .i_msg (r_msg),
                .i_row (Parray[w_row_idx[j]]),
                .o_par (w_par_bits[j])
            );
        end
    endgenerate

    // Merge this group's bits so the final edge can register the full parity.
    always_comb begin
        w_par_next = r_par;
        for (int j = 0; j < PAR_PER_CYC; j++) begin
            w_par_next[w_row_idx[j]] = w_par_bits[j];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_grp   <= '0;
            r_msg   <= '0;
            r_par   <= '0;
            cw      <= '0;
            valid   <= 1'b0;
            free    <= 1'b1;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (work) begin
                        r_msg   <= msg;
                        r_par   <= '0;
                        r_grp   <= '0;
                        free    <= 1'b0;
                        r_state <= c_CALC;
                    end
                end
                c_CALC: begin
                    r_par <= w_par_next;
                    r_grp <= r_grp + c_GW'(1);
                    if (r_grp == c_LAST_GRP) begin
                        cw      <= {r_msg, w_par_next};
                        valid   <= 1'b1;
                        r_state <= c_DONE;
                    end
                end
                c_DONE: begin
                    valid   <= 1'b0;
                    free    <= 1'b1;
                    r_state <= c_IDLE;
                end
                default: begin
                    valid   <= 1'b0;
                    free    <= 1'b1;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ldpc_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ldpc_encoder
// Description : Self-checking bench for ldpc_encoder against a GF(2) model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ldpc_encoder;
    import ldpc_pkg::*;

    localparam int c_LAT = M / PAR_PER_CYC;

    logic         clk_tb = 1'b0;
    logic         rst    = 1'b1;
    logic         work   = 1'b0;
    logic [K-1:0] msg    = '0;
    logic         free;
    logic         valid;
    logic [N-1:0] cw;

    int checks   = 0;
    int failures = 0;

    logic [K-1:0] pmat [M];

    typedef struct {
        logic [K-1:0] m;
        logic [N-1:0] exp;
        string        name;
    } vec_t;
    vec_t tbl [5];

    always #5 clk_tb = ~clk_tb;

    ldpc_encoder #(
        .N           (N),
        .K           (K),
        .PAR_PER_CYC (PAR_PER_CYC)
    ) dut (
        .clk   (clk_tb),
        .rst   (rst),
        .work  (work),
        .msg   (msg),
        .free  (free),
        .cw    (cw),
        .valid (valid)
    );

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [N-1:0] ref_cw(input logic [K-1:0] m);
        logic [M-1:0] p;
        for (int i = 0; i < M; i++) p[i] = (($countones(m & pmat[i]) % 2) == 1);
        return {m, p};
    endfunction

    function automatic logic [K-1:0] rnd_msg();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic load_pmat(input bit ident);
        for (int i = 0; i < M; i++) begin
            pmat[i] = ident ? (K'(1) << i) : rnd_msg();
            dut.Parray[i] = pmat[i];
        end
    endtask

    task automatic tick();
        @(posedge clk_tb);
        #1;
    endtask

    // Full encode with latency, free-low window, valid width and hold checks.
    task automatic encode(input logic [K-1:0] m, input logic [N-1:0] exp, input string name);
        int           lat;
        bit           free_low;
        logic [N-1:0] got;
        lat = 0;
        @(negedge clk_tb);
        work = 1'b1;
        msg  = m;
        tick();
        work     = 1'b0;
        msg      = ~m;
        free_low = (free == 1'b0);
        for (int e = 1; e <= 40; e++) begin
            tick();
            if (free) free_low = 1'b0;
            if (valid) begin
                lat = e;
                break;
            end
        end
        got = cw;
        chk({name, "_latency"}, N'(lat), N'(c_LAT));
        chk({name, "_cw"}, got, exp);
        chk({name, "_free_low"}, N'(free_low), N'(1));
        tick();
        chk({name, "_after_valid_free"}, N'({valid, free}), N'(2'b01));
        chk({name, "_cw_hold"}, cw, got);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [K-1:0] m1;
        logic [K-1:0] m2;
        logic [K-1:0] one5;
        logic [M-1:0] exp_p;
        int           lat;
        bit           seen;

        #12 rst = 1'b0;
        #1;
        chk("reset_free", N'(free), N'(1));
        chk("reset_valid", N'(valid), N'(0));
        chk("reset_cw", cw, '0);

        // Identity matrix: parity equals the message.
        load_pmat(1'b1);
        tbl[0] = '{128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
                   {128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
                    128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210}, "ident_pattern"};
        tbl[1] = '{'0, '0, "ident_zero"};
        tbl[2] = '{'1, '1, "ident_ones"};
        tbl[3] = '{K'(1) << 5, {K'(1) << 5, K'(1) << 5}, "ident_bit5"};
        tbl[4] = '{K'(1) << 127, {K'(1) << 127, K'(1) << 127}, "ident_msb"};
        for (int i = 0; i < 5; i++) encode(tbl[i].m, tbl[i].exp, tbl[i].name);

        load_pmat(1'b0);
        encode('0, '0, "zero_msg");

        one5 = K'(1) << 5;
        encode(one5, ref_cw(one5), "bit5_msg");
        for (int i = 0; i < M; i++) exp_p[i] = pmat[i][5];
        chk("bit5_parity_col", N'(cw[MSG_LSB-1:0]), N'(exp_p));
        chk("bit5_msg_field", N'(cw[N-1:MSG_LSB]), N'(one5));

        for (int r = 0; r < 12; r++) begin
            m1 = rnd_msg();
            encode(m1, ref_cw(m1), $sformatf("rand%0d", r));
        end

        // work re-pulsed mid-encode is ignored.
        m1 = rnd_msg();
        m2 = ~m1;
        lat = 0;
        @(negedge clk_tb);
        work = 1'b1;
        msg  = m1;
        tick();
        work = 1'b0;
        msg  = m2;
        tick();
        tick();
        work = 1'b1;
        tick();
        work = 1'b0;
        for (int e = 4; e <= 40; e++) begin
            tick();
            if (valid) begin
                lat = e;
                break;
            end
        end
        chk("repulse_latency", N'(lat), N'(c_LAT));
        chk("repulse_cw", cw, ref_cw(m1));
        tick();
        tick();
        chk("repulse_no_queue", N'({free, valid}), N'(2'b10));

        // Asynchronous reset mid-encode.
        m1 = rnd_msg();
        @(negedge clk_tb);
        work = 1'b1;
        msg  = m1;
        tick();
        work = 1'b0;
        repeat (7) tick();
        #3 rst = 1'b1;
        #1;
        chk("abort_async_cw", cw, '0);
        chk("abort_async_flags", N'({free, valid}), N'(2'b10));
        @(posedge clk_tb);
        #3 rst = 1'b0;
        seen = 1'b0;
        for (int e = 0; e < 25; e++) begin
            tick();
            if (valid) seen = 1'b1;
        end
        chk("abort_no_valid", N'(seen), N'(0));
        chk("abort_free", N'(free), N'(1));
        chk("abort_cw_zero", cw, '0);

        // work held high: second encode sampled at E+18.
        m1 = rnd_msg();
        m2 = rnd_msg();
        lat = 0;
        @(negedge clk_tb);
        work = 1'b1;
        msg  = m1;
        tick();
        for (int e = 1; e <= 18; e++) begin
            tick();
            if (e == c_LAT) begin
                chk("held_first_valid", N'(valid), N'(1));
                chk("held_first_cw", cw, ref_cw(m1));
                msg = m2;
            end
            if (e == c_LAT + 1) chk("held_free_back", N'(free), N'(1));
        end
        work = 1'b0;
        for (int e = 19; e <= 60; e++) begin
            tick();
            if (valid) begin
                lat = e;
                break;
            end
        end
        chk("held_second_latency", N'(lat), N'(2 * c_LAT + 2));
        chk("held_second_cw", cw, ref_cw(m2));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
